// File: rtl/uiip_arp_rx.sv
// rtl/uiip_arp_rx.sv - MAC receive demux to the IP and ARP receive paths
// Per-frame routing decision on the start beat, registered forwarding, saturating debug counters.
module uiip_arp_rx #(
  parameter int MAX_LEN     = 1500,
  parameter int ARP_MIN_LEN = 28,
  parameter int CNT_W       = 16
) (
  input  logic             I_ip_arp_clk,
  input  logic             I_ip_arp_reset_n,
  input  logic             I_mac_rvalid,
  input  logic [7:0]       I_mac_rdata,
  input  logic [1:0]       I_mac_rdata_type,
  input  logic [47:0]      I_mac_rsrc_addr,
  input  logic             I_ip_rbusy,
  input  logic             I_arp_rbusy,
  output logic             O_ip_rvalid,
  output logic [7:0]       O_ip_rdata,
  output logic [47:0]      O_ip_rsrc_mac,
  output logic             O_ip_rdone,
  output logic             O_ip_rerr,
  output logic             O_arp_rvalid,
  output logic [7:0]       O_arp_rdata,
  output logic [47:0]      O_arp_rsrc_mac,
  output logic             O_arp_rdone,
  output logic             O_arp_rerr,
  output logic [CNT_W-1:0] O_ip_pkt_cnt,
  output logic [CNT_W-1:0] O_arp_pkt_cnt,
  output logic [CNT_W-1:0] O_drop_cnt
);

  typedef enum logic [1:0] {IDLE, IP_PASS, ARP_PASS, DROP} state_e;

  localparam logic [15:0] MAX_LEN16 = 16'(MAX_LEN);
  localparam logic [15:0] ARP_MIN16 = 16'(ARP_MIN_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic              rvalid_q;
  logic [15:0]       bcnt_q, bcnt_d;
  logic              trunc_q, trunc_d;
  logic              ip_rvalid_q, ip_rvalid_d;
  logic [7:0]        ip_rdata_q, ip_rdata_d;
  logic [47:0]       ip_mac_q, ip_mac_d;
  logic              ip_rdone_q, ip_rdone_d;
  logic              ip_rerr_q, ip_rerr_d;
  logic              arp_rvalid_q, arp_rvalid_d;
  logic [7:0]        arp_rdata_q, arp_rdata_d;
  logic [47:0]       arp_mac_q, arp_mac_d;
  logic              arp_rdone_q, arp_rdone_d;
  logic              arp_rerr_q, arp_rerr_d;
  logic [CNT_W-1:0]  ip_cnt_q, ip_cnt_d;
  logic [CNT_W-1:0]  arp_cnt_q, arp_cnt_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic              start;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // rvalid_q resets high so a frame already running at reset release is not a start
  assign start = I_mac_rvalid && !rvalid_q;

  always_comb begin
    state_d      = state_q;
    bcnt_d       = bcnt_q;
    trunc_d      = trunc_q;
    ip_rvalid_d  = 1'b0;
    ip_rdata_d   = 8'd0;
    ip_mac_d     = ip_mac_q;
    ip_rdone_d   = 1'b0;
    ip_rerr_d    = 1'b0;
    arp_rvalid_d = 1'b0;
    arp_rdata_d  = 8'd0;
    arp_mac_d    = arp_mac_q;
    arp_rdone_d  = 1'b0;
    arp_rerr_d   = 1'b0;
    ip_cnt_d     = ip_cnt_q;
    arp_cnt_d    = arp_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bcnt_d  = 16'd1;
          trunc_d = 1'b0;
          if (I_mac_rdata_type == 2'b01 && !I_ip_rbusy) begin
            state_d     = IP_PASS;
            ip_mac_d    = I_mac_rsrc_addr;
            ip_rvalid_d = 1'b1;
            ip_rdata_d  = I_mac_rdata;
          end else if (I_mac_rdata_type == 2'b10 && !I_arp_rbusy) begin
            state_d      = ARP_PASS;
            arp_mac_d    = I_mac_rsrc_addr;
            arp_rvalid_d = 1'b1;
            arp_rdata_d  = I_mac_rdata;
          end else begin
            state_d = DROP;
          end
        end
      end
      IP_PASS: begin
        if (!I_mac_rvalid) begin
          state_d    = IDLE;
          ip_rdone_d = 1'b1;
          ip_cnt_d   = sat_inc(ip_cnt_q);
        end else if (bcnt_q == MAX_LEN16) begin
          state_d    = DROP;
          trunc_d    = 1'b1;
          bcnt_d     = bcnt_q + 16'd1;
          ip_rdone_d = 1'b1;
          ip_rerr_d  = 1'b1;
          drop_cnt_d = sat_inc(drop_cnt_q);
        end else begin
          bcnt_d      = bcnt_q + 16'd1;
          ip_rvalid_d = 1'b1;
          ip_rdata_d  = I_mac_rdata;
        end
      end
      ARP_PASS: begin
        if (!I_mac_rvalid) begin
          state_d     = IDLE;
          arp_rdone_d = 1'b1;
          if (bcnt_q < ARP_MIN16) begin
            arp_rerr_d = 1'b1;
            drop_cnt_d = sat_inc(drop_cnt_q);
          end else begin
            arp_cnt_d = sat_inc(arp_cnt_q);
          end
        end else if (bcnt_q == MAX_LEN16) begin
          state_d     = DROP;
          trunc_d     = 1'b1;
          bcnt_d      = bcnt_q + 16'd1;
          arp_rdone_d = 1'b1;
          arp_rerr_d  = 1'b1;
          drop_cnt_d  = sat_inc(drop_cnt_q);
        end else begin
          bcnt_d       = bcnt_q + 16'd1;
          arp_rvalid_d = 1'b1;
          arp_rdata_d  = I_mac_rdata;
        end
      end
      DROP: begin
        // A truncated frame was already counted when it was cut
        if (!I_mac_rvalid) begin
          state_d = IDLE;
          trunc_d = 1'b0;
          if (!trunc_q) drop_cnt_d = sat_inc(drop_cnt_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge I_ip_arp_clk or negedge I_ip_arp_reset_n) begin
    if (!I_ip_arp_reset_n) begin
      state_q      <= IDLE;
      rvalid_q     <= 1'b1;
      bcnt_q       <= 16'd0;
      trunc_q      <= 1'b0;
      ip_rvalid_q  <= 1'b0;
      ip_rdata_q   <= 8'd0;
      ip_mac_q     <= 48'd0;
      ip_rdone_q   <= 1'b0;
      ip_rerr_q    <= 1'b0;
      arp_rvalid_q <= 1'b0;
      arp_rdata_q  <= 8'd0;
      arp_mac_q    <= 48'd0;
      arp_rdone_q  <= 1'b0;
      arp_rerr_q   <= 1'b0;
      ip_cnt_q     <= '0;
      arp_cnt_q    <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      rvalid_q     <= I_mac_rvalid;
      bcnt_q       <= bcnt_d;
      trunc_q      <= trunc_d;
      ip_rvalid_q  <= ip_rvalid_d;
      ip_rdata_q   <= ip_rdata_d;
      ip_mac_q     <= ip_mac_d;
      ip_rdone_q   <= ip_rdone_d;
      ip_rerr_q    <= ip_rerr_d;
      arp_rvalid_q <= arp_rvalid_d;
      arp_rdata_q  <= arp_rdata_d;
      arp_mac_q    <= arp_mac_d;
      arp_rdone_q  <= arp_rdone_d;
      arp_rerr_q   <= arp_rerr_d;
      ip_cnt_q     <= ip_cnt_d;
      arp_cnt_q    <= arp_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign O_ip_rvalid    = ip_rvalid_q;
  assign O_ip_rdata     = ip_rdata_q;
  assign O_ip_rsrc_mac  = ip_mac_q;
  assign O_ip_rdone     = ip_rdone_q;
  assign O_ip_rerr      = ip_rerr_q;
  assign O_arp_rvalid   = arp_rvalid_q;
  assign O_arp_rdata    = arp_rdata_q;
  assign O_arp_rsrc_mac = arp_mac_q;
  assign O_arp_rdone    = arp_rdone_q;
  assign O_arp_rerr     = arp_rerr_q;
  assign O_ip_pkt_cnt   = ip_cnt_q;
  assign O_arp_pkt_cnt  = arp_cnt_q;
  assign O_drop_cnt     = drop_cnt_q;

endmodule
